// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flop, LSB first.
// Optional signed-overflow output ovf is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bout_q, bout_d;

  // Full-subtractor cell inputs and outputs for the current bit
  logic             cell_x, cell_y, cell_z;
  logic             cell_d, cell_borrow;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    cell_x      = a_sr_q[0];
    cell_y      = b_sr_q[0];
    cell_z      = borrow_q;
    cell_d      = cell_x ^ cell_y ^ cell_z;
    cell_borrow = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & cell_z);
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    work_d   = work_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          work_d   = '0;
          borrow_d = bin;
          cnt_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        work_d   = {cell_d, work_q[WIDTH-1:1]};
        borrow_d = cell_borrow;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Final bit: the shifted working register is the complete result
          diff_d  = {cell_d, work_q[WIDTH-1:1]};
          bout_d  = cell_borrow;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      work_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      work_q   <= work_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor: WIDTH=8 directed vectors and WIDTH=4 exhaustive sweep.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;

  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf4;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_start4 = 0;
  int n_done4  = 0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .bin   (bin4),
    .busy  (busy4),
    .done  (done4),
    .diff  (diff4),
    .bout  (bout4)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done4) n_done4++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation; lat = edges from the accepting edge to done, bcnt = busy samples seen
  task automatic op8(input logic [7:0] a_i, input logic [7:0] b_i, input logic bin_i,
                     output int lat, output int bcnt);
    a8 = a_i; b8 = b_i; bin8 = bin_i; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!done8 && lat < 30) begin
      if (busy8) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic op4(input logic [3:0] a_i, input logic [3:0] b_i, input logic bin_i,
                     output int lat);
    a4 = a_i; b4 = b_i; bin4 = bin_i; start4 = 1'b1;
    n_start4++;
    tick();
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, ndone, first, last, unstable;
    logic [4:0] ref5;
    logic [3:0] ai, bi;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_diff", 32'(diff8), 32'd0);
    check("reset_bout", 32'(bout8), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf", 32'(ovf8), 32'd0);
`endif

    // 0x5A - 0x23 = 0x37
    op8(8'h5A, 8'h23, 1'b0, lat, bcnt);
    check("5a_latency", 32'(lat), 32'd8);
    check("5a_busy_cycles", 32'(bcnt), 32'd8);
    check("5a_diff", 32'(diff8), 32'h37);
    check("5a_bout", 32'(bout8), 32'd0);
    check("5a_busy_in_done", 32'(busy8), 32'd0);
    tick();
    check("5a_done_one_cycle", 32'(done8), 32'd0);
    check("5a_diff_hold", 32'(diff8), 32'h37);

    op8(8'h00, 8'h01, 1'b0, lat, bcnt);
    check("00m01_diff", 32'(diff8), 32'hFF);
    check("00m01_bout", 32'(bout8), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
    check("00m01_ovf", 32'(ovf8), 32'd0);
`endif
    tick();

    op8(8'h10, 8'h10, 1'b1, lat, bcnt);
    check("10m10b_diff", 32'(diff8), 32'hFF);
    check("10m10b_bout", 32'(bout8), 32'd1);
    tick();

    op8(8'h80, 8'h01, 1'b0, lat, bcnt);
    check("80m01_diff", 32'(diff8), 32'h7F);
    check("80m01_bout", 32'(bout8), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("80m01_ovf", 32'(ovf8), 32'd1);
`endif
    tick();

    op8(8'h7F, 8'hFF, 1'b0, lat, bcnt);
    check("7fmff_diff", 32'(diff8), 32'h80);
    check("7fmff_bout", 32'(bout8), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
    check("7fmff_ovf", 32'(ovf8), 32'd1);
`endif
    tick();

    // Held start: DONE ignores start and IDLE must be re-entered, so accepts repeat every 10 edges
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    ndone = 0; first = -1; last = -1; unstable = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 12) a8 = 8'h55;
      if (done8) begin
        ndone++;
        if (ndone == 1) first = c;
        last = c;
      end
      if (c >= 9 && c < 29 && diff8 !== 8'h22) unstable++;
    end
    start8 = 1'b0;
    check("held_done_count", 32'(ndone), 32'd4);
    check("held_first_done", 32'(first), 32'd9);
    check("held_period_x3", 32'(last - first), 32'd30);
    check("held_diff_stable", 32'(unstable), 32'd0);
    check("held_late_capture", 32'(diff8), 32'h44);
    repeat (2) tick();

    // Reset during the 4th SHIFT cycle
    a8 = 8'hFF; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_diff", 32'(diff8), 32'd0);
    check("abort_bout", 32'(bout8), 32'd0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done8) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    op8(8'hFF, 8'h01, 1'b0, lat, bcnt);
    check("after_abort_latency", 32'(lat), 32'd8);
    check("after_abort_diff", 32'(diff8), 32'hFE);
    check("after_abort_bout", 32'(bout8), 32'd0);
    tick();

    // WIDTH=4 exhaustive sweep against a 5-bit reference subtraction
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          ai = 4'(ia);
          bi = 4'(ib);
          ref5 = {1'b0, ai} - {1'b0, bi} - 5'(ic);
          op4(ai, bi, 1'(ic), lat);
          check($sformatf("w4_lat_%0d_%0d_%0d", ia, ib, ic), 32'(lat), 32'd4);
          check($sformatf("w4_diff_%0d_%0d_%0d", ia, ib, ic), 32'(diff4), 32'(ref5[3:0]));
          check($sformatf("w4_bout_%0d_%0d_%0d", ia, ib, ic), 32'(bout4), 32'(ref5[4]));
`ifdef SERIAL_SUB_OVF_EN
          check($sformatf("w4_ovf_%0d_%0d_%0d", ia, ib, ic), 32'(ovf4),
                32'((ai[3] ^ bi[3]) & (ref5[3] ^ ai[3])));
`endif
          tick();
        end
      end
    end
    tick();
    check("w4_done_count", 32'(n_done4), 32'(n_start4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
